// File: rtl/serial_word_receiver_pkg.sv
// Shared definitions for the serial word receiver.
//   WORD_W  : width of the collected parallel word
//   CNT_W   : width of the bit counter (counts 0..WORD_W-1, wraps on the last bit)
//   state_t : receiver FSM state encoding
package serial_word_receiver_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    HOLD  = 2'b10
  } state_t;

endpackage

// File: rtl/serial_word_receiver_bit_counter.sv
// bit_counter: frame bit counter for the serial word receiver.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   clr   : restart the count (a new frame begins this cycle)
//   en    : a bit is accepted this cycle
//   cnt   : bits accepted so far in the current frame
//   last  : this cycle accepts the final bit of a word (count wraps to 0)
module bit_counter
  import serial_word_receiver_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      // A restart that also carries a valid bit counts that bit as bit 1.
      cnt <= en ? CNT_W'(1) : '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // A clearing cycle can never be a completion: the restart wins.
  assign last = en && !clr && (cnt == '1);

endmodule

// File: rtl/serial_word_receiver.sv
// serial_word_receiver: collects WORD_W serial bits (MSB first) into a parallel
// word and offers it to a consumer with a valid/ready handshake.
//   clk       : system clock, rising edge
//   reset     : asynchronous active-low reset
//   start     : begin a new frame (discarding any partial frame)
//   sin       : serial data bit
//   sin_valid : sin carries a valid bit this cycle
//   p_out     : last completed word; the first received bit is p_out[WORD_W-1]
//   out_valid : p_out holds a word not yet taken by the consumer
//   out_ready : consumer accepts p_out
//   busy      : a frame is being collected
//   bit_cnt   : bits accepted in the current frame
//   overrun   : sticky; a start arrived while a word was still waiting
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | collecting bits of a frame
// HOLD  | complete word on p_out, waiting for out_ready
module serial_word_receiver #(
  parameter int WORD_W = 32
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  sin,
  input  logic                                  sin_valid,
  output logic [WORD_W-1:0]                     p_out,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  busy,
  output logic [serial_word_receiver_pkg::CNT_W-1:0] bit_cnt,
  output logic                                  overrun
);

  import serial_word_receiver_pkg::*;

  state_t state;
  state_t state_nxt;

  // Only the most recent WORD_W-1 bits are kept: the final bit of a word
  // goes straight from sin into p_out, so a full-width register is not needed.
  logic [WORD_W-2:0] shreg;

  logic take_start;
  logic cnt_en;
  logic cnt_last;
  logic word_done;

  // A start is honoured everywhere except in HOLD while the word is still
  // unaccepted; there it only raises overrun.
  assign take_start = start && ((state != HOLD) || out_ready);
  assign cnt_en     = sin_valid && (take_start || (state == SHIFT));
  assign word_done  = (state == SHIFT) && cnt_last;

  bit_counter u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (take_start),
    .en    (cnt_en),
    .cnt   (bit_cnt),
    .last  (cnt_last)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (start) begin
          state_nxt = SHIFT;
        end else if (word_done) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = start ? SHIFT : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode
  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      SHIFT:   busy      = 1'b1;
      HOLD:    out_valid = 1'b1;
      default: begin
        busy      = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Data path
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg   <= '0;
      p_out   <= '0;
      overrun <= 1'b0;
    end else begin
      if (take_start) begin
        shreg <= sin_valid ? {{(WORD_W-2){1'b0}}, sin} : '0;
      end else if ((state == SHIFT) && sin_valid) begin
        shreg <= {shreg[WORD_W-3:0], sin};
      end

      if (word_done) begin
        p_out <= {shreg, sin};
      end

      if ((state == HOLD) && !out_ready && start) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_receiver.sv
module tb_serial_word_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sin;
  logic        sin_valid;
  logic        out_ready;
  logic [31:0] p_out;
  logic        out_valid;
  logic        busy;
  logic [4:0]  bit_cnt;
  logic        overrun;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb_q[$];
  logic ov_prev = 1'b0;

  typedef struct {
    logic [31:0] word;
    int          stall;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[6];

  serial_word_receiver #(.WORD_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sin       (sin),
    .sin_valid (sin_valid),
    .p_out     (p_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .bit_cnt   (bit_cnt),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every new word on the output must match the oldest
  // word the driver finished sending.
  always @(negedge clk) begin
    if (out_valid && !ov_prev) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got p_out=%h with no frame pending at %0t", p_out, $time);
      end else begin
        chk("sb_word", p_out, sb_q.pop_front());
      end
    end
    ov_prev = out_valid;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // All tasks start and end at a falling edge where inputs may be driven.
  task automatic start_frame();
    start = 1'b1;
    sin_valid = 1'b0;
    sin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("cnt_after_start", bit_cnt, 0);
  endtask

  task automatic send_raw(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      sin_valid = 1'b1;
      sin = w[31-i];
      @(negedge clk);
    end
    sin_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] w, input int from, input int stall, output int edges);
    int sent;
    int c;
    sent = from;
    c = 0;
    while (sent < 32) begin
      if (stall > 0 && (c % stall) == stall - 1) begin
        sin_valid = 1'b0;
      end else begin
        sin_valid = 1'b1;
        sin = w[31-sent];
        sent++;
        if (sent == 32) sb_q.push_back(w);
      end
      c++;
      @(negedge clk);
      chk("bit_cnt", bit_cnt, 32'(sent % 32));
      if (sent < 32) chk("no_early_valid", out_valid, 0);
    end
    sin_valid = 1'b0;
    chk("out_valid_latency", out_valid, 1);
    chk("busy_in_hold", busy, 0);
    chk("p_out_direct", p_out, w);
    edges = c;
  endtask

  task automatic accept(input logic [31:0] w);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_dropped", out_valid, 0);
    chk("idle_after_accept", busy, 0);
    chk("p_out_retained", p_out, w);
  endtask

  initial begin
    int edges;
    vecs[0] = '{32'hA5F0_3C81, 0, 32'hA5F0_3C81};
    vecs[1] = '{32'hA5F0_3C81, 3, 32'hA5F0_3C81};
    vecs[2] = '{32'h0000_0000, 0, 32'h0000_0000};
    vecs[3] = '{32'hFFFF_FFFF, 4, 32'hFFFF_FFFF};
    vecs[4] = '{32'h8000_0001, 0, 32'h8000_0001};
    vecs[5] = '{32'h1357_9BDF, 2, 32'h1357_9BDF};

    reset = 1'b0;
    start = 1'b0;
    sin = 1'b0;
    sin_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_p_out", p_out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    chk("rst_overrun", overrun, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Table of frames; the first start follows reset release immediately.
    for (int i = 0; i < 6; i++) begin
      start_frame();
      send_bits(vecs[i].word, 0, vecs[i].stall, edges);
      chk("tbl_p_out", p_out, vecs[i].exp_word);
      if (vecs[i].stall == 0) chk("tbl_latency", edges, 32);
      accept(vecs[i].exp_word);
    end

    // Restart after 10 bits: the partial frame leaves no trace.
    start_frame();
    send_raw($urandom, 10);
    chk("partial_cnt", bit_cnt, 10);
    start_frame();
    send_bits(32'h1234_5678, 0, 0, edges);
    accept(32'h1234_5678);

    // Start on the 32nd-bit cycle wins over completion.
    start_frame();
    send_raw(32'h3C5A_F069, 31);
    start = 1'b1;
    sin_valid = 1'b1;
    sin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("prio_no_valid", out_valid, 0);
    chk("prio_cnt", bit_cnt, 1);
    chk("prio_busy", busy, 1);
    send_bits(32'hC3A5_0F96, 1, 0, edges);
    accept(32'hC3A5_0F96);

    // Long HOLD, then handshake and start together.
    start_frame();
    send_bits(32'h5A5A_1234, 0, 0, edges);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_p_out", p_out, 32'h5A5A_1234);
    end
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    chk("b2b_valid_drop", out_valid, 0);
    chk("b2b_busy", busy, 1);
    chk("b2b_cnt", bit_cnt, 0);
    send_bits(32'hFFFF_0000, 0, 0, edges);
    accept(32'hFFFF_0000);

    // Overrun: start while the word waits.
    chk("overrun_clear", overrun, 0);
    start_frame();
    send_bits(32'hA5F0_3C81, 0, 3, edges);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("overrun_set", overrun, 1);
    chk("overrun_p_out", p_out, 32'hA5F0_3C81);
    chk("overrun_still_valid", out_valid, 1);
    chk("overrun_not_busy", busy, 0);
    accept(32'hA5F0_3C81);
    start_frame();
    send_bits(32'h0F0F_0F0F, 0, 0, edges);
    accept(32'h0F0F_0F0F);
    chk("overrun_sticky", overrun, 1);

    // Asynchronous reset at bit 20.
    start_frame();
    send_raw($urandom, 20);
    chk("pre_reset_cnt", bit_cnt, 20);
    sin_valid = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("areset_p_out", p_out, 0);
    chk("areset_valid", out_valid, 0);
    chk("areset_busy", busy, 0);
    chk("areset_cnt", bit_cnt, 0);
    chk("areset_overrun", overrun, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sin_valid = 1'b1;
      sin = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    sin_valid = 1'b0;
    chk("post_reset_no_valid", out_valid, 0);
    chk("post_reset_idle", busy, 0);
    chk("post_reset_cnt", bit_cnt, 0);
    @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_word_receiver.md
SERIAL_WORD_RECEIVER -- requirements
Module: serial_word_receiver

Interface
REQ-001 Parameter: WORD_W, 32, width of the collected parallel word; only 32 is supported.
REQ-002 Port: clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-004 Port: start  input  1  begins a new frame; sampled on the rising edge of clk.
REQ-005 Port: sin  input  1  serial data bit, driven by the upstream 32-bit shift register's sout.
REQ-006 Port: sin_valid  input  1  sin carries a valid bit this cycle.
REQ-007 Port: p_out  output  32  collected word; first-received bit lands in p_out[31].
REQ-008 Port: out_valid  output  1  p_out holds a complete word.
REQ-009 Port: out_ready  input  1  consumer accepts p_out.
REQ-010 Port: busy  output  1  1 while a frame is being collected (SHIFT state).
REQ-011 Port: bit_cnt  output  5  number of bits accepted in the current frame.
REQ-012 Port: overrun  output  1  sticky error flag; a start was lost.

Function
REQ-013 FSM states: IDLE, SHIFT, HOLD; the state register is updated on the rising edge of clk.
REQ-014 IDLE: start=1 moves to SHIFT, clears bit_cnt and the internal shift register; sin and sin_valid are otherwise ignored.
REQ-015 A start cycle with sin_valid=1 captures that sin as frame bit 1 (bit_cnt=1 next cycle).
REQ-016 SHIFT, sin_valid=1: shreg <= {shreg[30:0], sin}; bit_cnt increments by 1.
REQ-017 SHIFT, sin_valid=0: shreg and bit_cnt hold (stall); there is no timeout.
REQ-018 SHIFT, 32nd bit accepted: p_out <= {shreg[30:0], sin}, out_valid=1 in the next cycle, state goes to HOLD, bit_cnt wraps to 0.
REQ-019 SHIFT, start=1: the partial frame is discarded and collection restarts per REQ-014/015; start has priority over completion in the same cycle.
REQ-020 HOLD: p_out and out_valid=1 remain stable until out_ready=1; the handshake completes on a cycle where out_valid=1 and out_ready=1.
REQ-021 HOLD, out_ready=1, start=0: out_valid=0 in the next cycle; state goes to IDLE; p_out retains its last value.
REQ-022 HOLD, out_ready=1, start=1: the handshake completes and the block goes directly to SHIFT (back-to-back frames, no idle cycle).
REQ-023 HOLD, out_ready=0, start=1: start is ignored and overrun is set to 1.
REQ-024 HOLD: sin_valid is ignored.
REQ-025 overrun remains set until reset.
REQ-026 busy = (state == SHIFT), decoded combinationally from the state register.
REQ-027 Latency: out_valid rises exactly one clock after the edge that accepts the 32nd bit; the minimum frame length is 32 cycles.

Reset
REQ-028 reset=0 asynchronously forces: state=IDLE, shreg=0, p_out=0x00000000, out_valid=0, bit_cnt=0, overrun=0, busy=0.
REQ-029 Reset asserted mid-frame or during HOLD discards all data; no out_valid is produced for the interrupted frame.
REQ-030 After reset release, the first start is honoured on the first rising edge of clk.

Structure
REQ-031 The shared package holds WORD_W=32, CNT_W=5 and the state encodings IDLE=2'b00, SHIFT=2'b01, HOLD=2'b10.
REQ-032 A single sub-module, bit_counter (5-bit, with clear, enable and wrap), provides bit_cnt; the FSM and data path stay in serial_word_receiver.

Verification
REQ-033 Verification: start, then 32 continuous valid bits of 0xA5F03C81 MSB-first -> p_out=0xA5F03C81, out_valid=1 exactly 32 cycles after the start edge.
REQ-034 Verification: same word with sin_valid=0 on every third cycle -> same p_out; bit_cnt frozen during stalls; out_valid one cycle after the 32nd valid bit.
REQ-035 Verification: start, 10 bits, start again, then 32 bits of 0x12345678 -> p_out=0x12345678; the first 10 bits leave no trace.
REQ-036 Verification: hold out_ready=0 for 5 cycles in HOLD, then pulse start+out_ready together -> out_valid drops, busy=1 the next cycle, and the second word 0xFFFF0000 is captured correctly.
REQ-037 Verification: start in HOLD with out_ready=0 -> overrun=1, p_out unchanged; overrun persists through further frames until reset=0.
REQ-038 Verification: reset=0 asserted asynchronously at bit 20 -> all outputs 0 immediately; no out_valid afterwards without a new start.
